// File: rtl/acc_drain_reader.sv
// Accumulator bank drain: reads cfg_num_rows psum vectors from address 0 upward
// and streams them over valid/ready through a 2-entry credit-controlled FIFO.
module acc_drain_reader #(
  parameter int ARRAY_COL  = 12,
  parameter int ACC_WIDTH  = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [ADDR_WIDTH:0]            cfg_num_rows,
  output logic                           busy,
  output logic                           done,
  output logic                           acc_rd_en,
  output logic [ADDR_WIDTH-1:0]          acc_rd_addr,
  input  logic [ARRAY_COL*ACC_WIDTH-1:0] acc_rd_data,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [ARRAY_COL*ACC_WIDTH-1:0] m_data,
  output logic                           m_last
);

  localparam int DW = ARRAY_COL * ACC_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_FLUSH, S_DONE} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH:0]   rows_left;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  inflight, inflight_last;
  logic [DW-1:0]         fifo_data [2];
  logic                  fifo_last [2];
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            fifo_count;
  logic                  push, pop, rd_fire, last_read;
  logic [2:0]            credit_use;

  always_comb begin
    push       = inflight;
    m_valid    = (fifo_count != 2'd0);
    pop        = m_valid & m_ready;
    // Entries already held plus the read in flight, minus the beat leaving now.
    credit_use = {1'b0, fifo_count} + {2'b0, inflight} - {2'b0, pop};
    rd_fire    = (state == S_READ) && (rows_left != '0) && (credit_use < 3'd2);
    last_read  = rd_fire && (rows_left == (ADDR_WIDTH+1)'(1));
    acc_rd_en  = rd_fire;
    acc_rd_addr = rd_addr;
    m_data     = fifo_data[rd_ptr];
    m_last     = m_valid & fifo_last[rd_ptr];
    busy       = (state != S_IDLE);
    done       = (state == S_DONE);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (cfg_num_rows == '0) ? S_DONE : S_READ;
      S_READ:  if (last_read) state_nxt = S_FLUSH;
      S_FLUSH: if (pop && m_last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      rows_left     <= '0;
      rd_addr       <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      state         <= state_nxt;
      inflight      <= rd_fire;
      inflight_last <= last_read;
      if (state == S_IDLE && start) begin
        rows_left <= cfg_num_rows;
        rd_addr   <= '0;
      end else if (rd_fire) begin
        rows_left <= rows_left - (ADDR_WIDTH+1)'(1);
        rd_addr   <= rd_addr + ADDR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= acc_rd_data;
        fifo_last[wr_ptr] <= inflight_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_acc_drain_reader.sv
// Scoreboard bench for acc_drain_reader: bank model, randomized backpressure,
// expected beats queued at drain start and checked by an independent monitor.
module tb_acc_drain_reader;

  localparam int COLS = 12;
  localparam int AW   = 32;
  localparam int ADW  = 4;
  localparam int DW   = COLS * AW;
  localparam int DEPTH = 1 << ADW;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [ADW:0]   cfg_num_rows = '0;
  logic           busy, done, acc_rd_en, m_valid, m_last;
  logic           m_ready = 1'b1;
  logic [ADW-1:0] acc_rd_addr;
  logic [DW-1:0]  acc_rd_data = '0;
  logic [DW-1:0]  m_data;

  logic [DW-1:0]  bank [DEPTH];
  beat_t          sb [$];
  int             checks = 0;
  int             failures = 0;
  int             ready_mode = 0;
  int             drain_id = 0;
  int             seen_id = 0;
  int             exp_addr = 0;
  int             rd_in_drain = 0;
  int             taken_in_drain = 0;
  int             outstanding = 0;
  int             done_count = 0;
  logic           prev_stall = 1'b0;
  logic [DW-1:0]  prev_data = '0;
  logic           prev_last = 1'b0;

  acc_drain_reader #(.ARRAY_COL(COLS), .ACC_WIDTH(AW), .ADDR_WIDTH(ADW)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_num_rows(cfg_num_rows),
    .busy(busy), .done(done), .acc_rd_en(acc_rd_en), .acc_rd_addr(acc_rd_addr),
    .acc_rd_data(acc_rd_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Bank read port: one-cycle latency, garbage when not reading.
  always @(posedge clk) begin
    if (acc_rd_en) acc_rd_data <= bank[acc_rd_addr];
    else           acc_rd_data <= {COLS{$urandom}};
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ~m_ready;
      2:       m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      outstanding = 0;
      prev_stall  = 1'b0;
    end else begin
      if (drain_id != seen_id) begin
        seen_id = drain_id;
        exp_addr = 0;
        rd_in_drain = 0;
        taken_in_drain = 0;
      end
      if (acc_rd_en) begin
        chk("rd_addr", DW'(acc_rd_addr), DW'(exp_addr % DEPTH));
        exp_addr++;
        rd_in_drain++;
        outstanding++;
      end
      if (prev_stall) begin
        chk("stall_valid", DW'(m_valid), DW'(1));
        chk("stall_data", m_data, prev_data);
        chk("stall_last", DW'(m_last), DW'(prev_last));
      end
      if (m_valid && m_ready) begin
        outstanding--;
        taken_in_drain++;
        if (sb.size() == 0) begin
          chk("unexpected_beat", DW'(1), DW'(0));
        end else begin
          beat_t b;
          b = sb.pop_front();
          chk("beat_data", m_data, b.d);
          chk("beat_last", DW'(m_last), DW'(b.l));
        end
      end
      if (acc_rd_en || m_valid) chk("credit_le_2", DW'(outstanding <= 2), DW'(1));
      if (done) begin
        done_count++;
        chk("done_queue_empty", DW'(sb.size()), DW'(0));
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  task automatic fill_bank(input bit ramp);
    for (int a = 0; a < DEPTH; a++)
      for (int c = 0; c < COLS; c++)
        bank[a][c*AW +: AW] = ramp ? AW'(a) : $urandom;
  endtask

  // Drives a start pulse; returns just after the sampling edge.
  task automatic start_pulse(input int n, input bit accepted);
    assert (n <= DEPTH) else $error("cfg_num_rows out of legal range");
    if (accepted) begin
      for (int k = 0; k < n; k++) begin
        beat_t b;
        b.d = bank[k];
        b.l = (k == n - 1);
        sb.push_back(b);
      end
      drain_id++;
    end
    cfg_num_rows = (ADW+1)'(n);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int base);
    for (int i = 0; i < 600 && done_count == base; i++) begin
      @(negedge clk);
      #1;
    end
    chk("done_seen", DW'(done_count), DW'(base + 1));
    @(negedge clk);
    #1;
    chk("done_single", DW'(done), DW'(0));
    chk("busy_after", DW'(busy), DW'(0));
  endtask

  task automatic run_drain(input int n, input int mode);
    int base;
    ready_mode = mode;
    base = done_count;
    start_pulse(n, 1'b1);
    wait_done(base);
    chk("reads_total", DW'(rd_in_drain), DW'(n));
  endtask

  initial begin
    int base, k;
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int base, k;
    fill_bank(1'b1);
    repeat (3) @(negedge clk);
    chk("rst_busy", DW'(busy), DW'(0));
    chk("rst_done", DW'(done), DW'(0));
    chk("rst_rd_en", DW'(acc_rd_en), DW'(0));
    chk("rst_addr", DW'(acc_rd_addr), DW'(0));
    chk("rst_valid", DW'(m_valid), DW'(0));
    chk("rst_last", DW'(m_last), DW'(0));
    chk("rst_data", m_data, '0);
    #1 rst = 1'b0;
    @(negedge clk);

    // Ramp drain of 4 with exact latency.
    ready_mode = 0;
    base = done_count;
    start_pulse(4, 1'b1);
    @(negedge clk);
    chk("t1_first_rd", DW'(acc_rd_en), DW'(1));
    chk("t1_first_valid", DW'(m_valid), DW'(0));
    @(negedge clk);
    chk("t1_valid_c2", DW'(m_valid), DW'(0));
    @(negedge clk);
    chk("t1_valid_c3", DW'(m_valid), DW'(1));
    chk("t1_data0", m_data, bank[0]);
    k = 3;
    while (!done && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("t1_done_cycle", DW'(k), DW'(7));
    #1 wait_done(base);

    // Full-depth drain with alternating backpressure.
    fill_bank(1'b0);
    run_drain(16, 1);
    chk("t2_final_addr", DW'(exp_addr - 1), DW'(15));

    // Downstream held off for 10 cycles.
    ready_mode = 3;
    @(negedge clk);
    base = done_count;
    start_pulse(8, 1'b1);
    repeat (10) @(negedge clk);
    #1;
    chk("t3_reads_held", DW'(rd_in_drain), DW'(2));
    chk("t3_valid_held", DW'(m_valid), DW'(1));
    chk("t3_data_held", m_data, bank[0]);
    ready_mode = 0;
    wait_done(base);
    chk("t3_beats", DW'(taken_in_drain), DW'(8));

    // Empty drain.
    base = done_count;
    start_pulse(0, 1'b1);
    @(negedge clk);
    #1;
    chk("t4_done", DW'(done), DW'(1));
    repeat (3) @(negedge clk);
    #1;
    chk("t4_done_once", DW'(done_count), DW'(base + 1));
    chk("t4_no_reads", DW'(rd_in_drain), DW'(0));

    // Start during a drain is ignored.
    fill_bank(1'b0);
    base = done_count;
    start_pulse(10, 1'b1);
    repeat (4) @(negedge clk);
    #1 start_pulse(3, 1'b0);
    wait_done(base);
    chk("t5_reads", DW'(rd_in_drain), DW'(10));

    // Start while done is high is ignored.
    base = done_count;
    start_pulse(3, 1'b1);
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      #1;
    end
    cfg_num_rows = 5'd5;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("t5_done_start_busy", DW'(busy), DW'(0));
    chk("t5_done_start_cnt", DW'(done_count), DW'(base + 1));
    run_drain(5, 0);

    // Asynchronous reset mid-drain.
    fill_bank(1'b0);
    ready_mode = 0;
    base = done_count;
    start_pulse(8, 1'b1);
    for (int i = 0; i < 100 && taken_in_drain < 3; i++) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_busy", DW'(busy), DW'(0));
    chk("t6_rd_en", DW'(acc_rd_en), DW'(0));
    chk("t6_addr", DW'(acc_rd_addr), DW'(0));
    chk("t6_valid", DW'(m_valid), DW'(0));
    chk("t6_last", DW'(m_last), DW'(0));
    chk("t6_data", m_data, '0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("t6_no_done", DW'(done_count), DW'(base));
    run_drain(8, 2);

    for (int r = 0; r < 6; r++) begin
      fill_bank(1'b0);
      run_drain($urandom_range(1, DEPTH), $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
